cfg_stream_loader: RTL and testbench
====================================

# cfg_stream_loader

Configuration loader sitting directly upstream of the memory tile's configuration port. It accepts a stream of 32-bit address/data configuration words, buffers them in a small FIFO, filters them by tile ID, and issues single-cycle write or read strobes to the tile. Read-back data is captured after a fixed tile latency. An end-of-stream marker raises a sticky done flag. It replaces the testbench-only bitstream driver with synthesizable logic that sits in front of each tile.

## Interface
Parameters:
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥2)
- READ_LAT, 2, cycles from read strobe to valid tile read_data (≥1)

Ports:
- clk_in  input  1  clock, all logic rising-edge
- reset_n  input  1  asynchronous active-low reset
- tile_id  input  16  static ID of the attached tile
- cfg_valid  input  1  upstream word valid
- cfg_ready  output  1  FIFO can accept; equals !full
- cfg_addr  input  32  [15:0] target tile ID, [23:16] register index, [31:24] reserved (passed through)
- cfg_data  input  32  write data
- cfg_read  input  1  1 = read request, 0 = write
- cfg_last  input  1  final word of the stream
- config_addr  output  32  address to tile
- config_data  output  32  data to tile
- config_write  output  1  one-cycle write strobe
- config_read  output  1  one-cycle read strobe
- read_data  input  32  tile read-back bus
- rd_data  output  32  captured read value, held until next capture
- rd_valid  output  1  one-cycle pulse when rd_data updates
- done  output  1  sticky; set after the last word is processed
- wr_count  output  16  matched writes issued, saturating at 16'hFFFF
- drop_count  output  16  non-matching words dropped, saturating

## Operation
- Push when cfg_valid && cfg_ready. The stored entry is {addr, data, read, last}.
- FSM states: IDLE, WRITE, READ, WAIT, DONE.
- IDLE with FIFO non-empty: pop one entry.
  - ID match, write: load config_addr/config_data; go to WRITE.
  - ID match, read: load config_addr; go to READ.
  - Mismatch: drop the entry and increment drop_count. Go to DONE if last is set, otherwise stay in IDLE.
- WRITE: config_write=1 for this cycle only. Increment wr_count. Go to DONE if last, else IDLE.
- READ: config_read=1 for this cycle only. Load the wait counter with READ_LAT-1 and go to WAIT.
- WAIT: count down. At zero, capture read_data into rd_data, pulse rd_valid, then go to DONE if last, else IDLE.
- DONE: no pops. cfg_ready=0. done=1. Remains here until reset.
- config_addr/config_data hold their last loaded value between strobes.
- Counters saturate and never wrap.

## Timing
- Reset values: all outputs 0, FSM=IDLE, FIFO empty. After reset, cfg_ready=1.
- Push-to-strobe latency on an empty FIFO: word pushed at edge N, popped in cycle N+1, strobe high in cycle N+2.
- Write throughput: one matched write per 2 cycles.
- Read occupancy: 2+READ_LAT cycles. rd_valid rises READ_LAT cycles after config_read.
- FIFO full: cfg_ready=0 even if a pop happens in the same cycle; no combinational ready-from-pop path.
- Push and pop in the same cycle on a non-full FIFO: both occur and occupancy is unchanged.
- Asynchronous reset mid-read or mid-stream: strobes drop immediately, FIFO contents are discarded, rd_data clears, and done clears.
- cfg_last on a dropped word still enters DONE.

## Configuration
- CFG_BROADCAST_EN defined: cfg_addr[15:0]==16'hFFFF matches every tile.
  - Writes are issued normally.
  - Broadcast reads are treated as mismatches and dropped.
- Not defined: 16'hFFFF matches only when tile_id==16'hFFFF.

## Test plan
- Reset, tile_id=16'h18. Push write addr 32'h00050018, data 32'hDEADBEEF -> config_write high exactly 2 cycles after the push, config_addr=32'h00050018, config_data=32'hDEADBEEF, wr_count=1.
- Push 3 words with IDs 16'h18, 16'h19, 16'h18 -> exactly 2 write strobes, drop_count=1, wr_count=2.
- Read with READ_LAT=2 and tile read_data=32'h0000ABCD -> config_read pulses once, rd_valid pulses 2 cycles later, rd_data=32'h0000ABCD and held.
- Push 5 words back-to-back with the tile busy -> cfg_ready low after the 4th is held, no word lost, all 5 strobed in order.
- Last word (write) -> done=1 after its strobe, cfg_ready=0, further cfg_valid ignored. Assert reset_n=0 -> done=0 and cfg_ready=1 after release.
- Write to ID 16'hFFFF: with CFG_BROADCAST_EN -> strobe issued. Without it -> drop_count increments and no strobe.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// rtl/cfg_stream_loader.sv - config word FIFO, tile-ID filter and write/read strobe sequencer
// Optional feature macro: CFG_BROADCAST_EN (tile ID 16'hFFFF addresses every tile for writes)
module cfg_stream_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 2
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [15:0] tile_id,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cfg_read,
  input  logic        cfg_last,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        config_read,
  input  logic [31:0] read_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [15:0] wr_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 66;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_match;
  logic [EW-1:0] w_head;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_head_read;
  logic          w_head_last;

  logic          r_last;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_rd_data;
  logic [15:0]   r_wr_count;
  logic [15:0]   r_drop_count;

  // Full/empty come from registered pointers only, so ready never depends on a same-cycle pop.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign cfg_ready = !w_full && (r_state != S_DONE);
  assign w_push    = cfg_valid && cfg_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign {w_head_addr, w_head_data, w_head_read, w_head_last} = w_head;

`ifdef CFG_BROADCAST_EN
  // Broadcast ID hits every tile for writes; a broadcast read has no single owner and is dropped.
  assign w_match = (w_head_addr[15:0] == 16'hFFFF) ? !w_head_read
                                                   : (w_head_addr[15:0] == tile_id);
`else
  assign w_match = (w_head_addr[15:0] == tile_id);
`endif

  assign config_addr = r_addr;
  assign config_data = r_data;
  assign rd_data     = r_rd_data;
  assign wr_count    = r_wr_count;
  assign drop_count  = r_drop_count;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {cfg_addr, cfg_data, cfg_read, cfg_last};
  end

  // FIFO pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and strobe outputs; strobes are pure state decodes so reset kills them at once.
  always_comb begin
    w_next       = r_state;
    config_write = 1'b0;
    config_read  = 1'b0;
    rd_valid     = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_match)          w_next = w_head_read ? S_READ : S_WRITE;
          else if (w_head_last) w_next = S_DONE;
        end
      end
      S_WRITE: begin
        config_write = 1'b1;
        w_next       = r_last ? S_DONE : S_IDLE;
      end
      S_READ: begin
        config_read = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == '0) begin
          rd_valid = 1'b1;
          w_next   = r_last ? S_DONE : S_IDLE;
        end
      end
      S_DONE:  done = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, read-latency counter and read-back capture.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_wait    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_pop && w_match) begin
        r_addr <= w_head_addr;
        r_last <= w_head_last;
        if (!w_head_read) r_data <= w_head_data;
      end
      if (r_state == S_READ)                      r_wait <= CW'(READ_LAT - 1);
      else if (r_state == S_WAIT && r_wait != '0) r_wait <= r_wait - CW'(1);
      if (rd_valid) r_rd_data <= read_data;
    end
  end

  // Saturating write and drop counters.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_state == S_WRITE && r_wr_count != 16'hFFFF)     r_wr_count   <= r_wr_count + 16'd1;
      if (w_pop && !w_match && r_drop_count != 16'hFFFF)    r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb/tb_cfg_stream_loader.sv - directed self-checking bench for cfg_stream_loader
module tb_cfg_stream_loader;

  logic        clk_in;
  logic        reset_n;
  logic [15:0] tile_id;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_read;
  logic        cfg_last;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic        config_read;
  logic [31:0] read_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [15:0] wr_count;
  logic [15:0] drop_count;

  int n_cmp;
  int n_bad;
  int n_wr;
  int n_rd;
  int n_rv;
  logic [63:0] wr_log [$];

  cfg_stream_loader #(.FIFO_DEPTH(4), .READ_LAT(2)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .tile_id(tile_id),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_read(cfg_read), .cfg_last(cfg_last),
    .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read),
    .read_data(read_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .wr_count(wr_count), .drop_count(drop_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Strobe monitor: values seen at the rising edge belong to the cycle just ending.
  always @(posedge clk_in) begin
    if (config_write) begin
      n_wr++;
      wr_log.push_back({config_addr, config_data});
    end
    if (config_read) n_rd++;
    if (rd_valid)    n_rv++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    n_wr = 0;
    n_rd = 0;
    n_rv = 0;
    wr_log.delete();
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
  endtask

  // Present one word at a falling edge, hold until accepted; returns at the falling edge after acceptance.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic r, input logic l);
    int tries;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_read  = r;
    cfg_last  = l;
    tries = 0;
    while (!cfg_ready && tries < 50) begin
      @(negedge clk_in);
      tries++;
    end
    if (tries >= 50) chk("push_timeout", 64'(tries), 64'd0);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tile_id   = 16'h0018;
    read_data = 32'h0000ABCD;
    cfg_addr  = '0;
    cfg_data  = '0;
    cfg_read  = 1'b0;
    cfg_last  = 1'b0;
    cfg_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk_in);
    do_reset();

    // Reset state
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_config_addr", config_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_strobes", {config_write, config_read, rd_valid}, 0);

    // Single write: strobe two cycles after the push edge
    push(32'h00050018, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("w1_no_strobe_n1", config_write, 0);
    @(negedge clk_in);
    chk("w1_strobe_n2", config_write, 1);
    chk("w1_addr", config_addr, 32'h00050018);
    chk("w1_data", config_data, 32'hDEADBEEF);
    @(negedge clk_in);
    chk("w1_strobe_off", config_write, 0);
    chk("w1_wr_count", wr_count, 1);
    chk("w1_addr_held", config_addr, 32'h00050018);

    // ID filter: 18, 19, 18
    do_reset();
    push(32'h00010018, 32'h00000001, 1'b0, 1'b0);
    push(32'h00020019, 32'h00000002, 1'b0, 1'b0);
    push(32'h00030018, 32'h00000003, 1'b0, 1'b0);
    repeat (10) @(negedge clk_in);
    chk("flt_strobes", 64'(n_wr), 2);
    chk("flt_wr_count", wr_count, 2);
    chk("flt_drop_count", drop_count, 1);
    chk("flt_first", (wr_log.size() > 0) ? wr_log[0] : 64'hX, 64'h00010018_00000001);
    chk("flt_second", (wr_log.size() > 1) ? wr_log[1] : 64'hX, 64'h00030018_00000003);

    // Read with READ_LAT=2
    do_reset();
    read_data = 32'h0000ABCD;
    push(32'h00070018, 32'h0, 1'b1, 1'b0);
    chk("rd_no_strobe_n1", config_read, 0);
    @(negedge clk_in);
    chk("rd_strobe", config_read, 1);
    chk("rd_addr", config_addr, 32'h00070018);
    @(negedge clk_in);
    chk("rd_wait1", {config_read, rd_valid}, 0);
    @(negedge clk_in);
    chk("rd_valid_lat", rd_valid, 1);
    @(negedge clk_in);
    chk("rd_valid_off", rd_valid, 0);
    chk("rd_data", rd_data, 32'h0000ABCD);
    read_data = 32'h00001234;
    repeat (3) @(negedge clk_in);
    chk("rd_data_held", rd_data, 32'h0000ABCD);
    chk("rd_pulses", {32'(n_rd), 32'(n_rv)}, {32'd1, 32'd1});

    // Reset in the middle of a read
    push(32'h00080018, 32'h0, 1'b1, 1'b0);
    @(negedge clk_in);
    chk("mid_rd_pre", config_read, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rd_strobe_drop", config_read, 0);
    chk("mid_rd_data_clear", rd_data, 0);
    chk("mid_rd_ready", cfg_ready, 1);
    do_reset();

    // Back-to-back stream behind a busy read: FIFO fills, nothing lost
    read_data = 32'h0000ABCD;
    push(32'h00010018, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) push(32'h00100018 + 32'(i << 16), 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("full_ready_low", cfg_ready, 0);
    push(32'h00150018, 32'h105, 1'b0, 1'b0);
    repeat (20) @(negedge clk_in);
    chk("full_strobes", 64'(n_wr), 5);
    for (int i = 1; i <= 5; i++)
      chk($sformatf("full_order%0d", i), (wr_log.size() >= i) ? wr_log[i-1] : 64'hX,
          {32'h00100018 + 32'(i << 16), 32'h100 + 32'(i)});
    chk("full_wr_count", wr_count, 5);
    chk("full_rd", {32'(n_rd), 32'(n_rv)}, {32'd1, 32'd1});
    chk("full_rd_data", rd_data, 32'h0000ABCD);

    // Last word sets sticky done
    do_reset();
    push(32'h00020018, 32'h00000055, 1'b0, 1'b1);
    repeat (3) @(negedge clk_in);
    chk("last_done", done, 1);
    chk("last_ready", cfg_ready, 0);
    chk("last_wr_count", wr_count, 1);
    cfg_valid = 1'b1;
    cfg_addr  = 32'h00030018;
    cfg_data  = 32'h00000066;
    cfg_read  = 1'b0;
    cfg_last  = 1'b0;
    repeat (5) @(negedge clk_in);
    cfg_valid = 1'b0;
    chk("last_ignored", 64'(n_wr), 1);
    chk("last_done_sticky", done, 1);
    reset_n = 1'b0;
    #1;
    chk("last_rst_done", done, 0);
    chk("last_rst_ready", cfg_ready, 1);
    do_reset();
    chk("last_post_done", done, 0);
    chk("last_post_ready", cfg_ready, 1);

    // Broadcast ID write, also the last word
    do_reset();
    push(32'h0003FFFF, 32'h00000077, 1'b0, 1'b1);
    repeat (6) @(negedge clk_in);
`ifdef CFG_BROADCAST_EN
    chk("bc_strobes", 64'(n_wr), 1);
    chk("bc_drop", drop_count, 0);
`else
    chk("bc_strobes", 64'(n_wr), 0);
    chk("bc_drop", drop_count, 1);
`endif
    chk("bc_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
